// File: rtl/output_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : output_sequencer
// Description : Frames NUM_RESULTS 32-bit results into lower/upper 9-bit
//               halves for the output serialiser, with valid/ready/last framing.
// Revision    : 1.0 - initial release
// ============================================================================
module output_sequencer #(
    parameter int NUM_RESULTS = 4,
    parameter int CNT_W       = $clog2(NUM_RESULTS + 1)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        res_valid,
    input  logic [31:0] res_data,
    output logic        res_ready,
    output logic [31:0] word_out,
    output logic        sel_upper,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic        busy,
    output logic        done,
    output logic        ovf
);

    localparam logic [2:0] c_IDLE     = 3'd0;
    localparam logic [2:0] c_WAIT_RES = 3'd1;
    localparam logic [2:0] c_SEND_LO  = 3'd2;
    localparam logic [2:0] c_SEND_HI  = 3'd3;
    localparam logic [2:0] c_DONE     = 3'd4;

    localparam logic [CNT_W-1:0] c_LAST_IDX = CNT_W'(NUM_RESULTS - 1);

    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic [CNT_W-1:0] r_count;
    logic [31:0]      r_word;
    logic             r_ovf;
    logic             w_is_last;
    logic             w_start_frame;
    logic             w_accept_res;
    logic             w_accept_hi;

    assign w_is_last     = (r_count == c_LAST_IDX);
    assign w_start_frame = (r_state == c_IDLE) && start;
    assign w_accept_res  = (r_state == c_WAIT_RES) && res_valid;
    assign w_accept_hi   = (r_state == c_SEND_HI) && out_ready;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:     if (start)     w_state_nxt = c_WAIT_RES;
            c_WAIT_RES: if (res_valid) w_state_nxt = c_SEND_LO;
            c_SEND_LO:  if (out_ready) w_state_nxt = c_SEND_HI;
            c_SEND_HI:  if (out_ready) w_state_nxt = w_is_last ? c_DONE : c_WAIT_RES;
            c_DONE:                    w_state_nxt = c_IDLE;
            default:                   w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // word_out only moves on an upstream accept, so the serialiser's upper
    // half stays intact however long the downstream stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            r_word  <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_start_frame) begin
                r_count <= '0;
                r_ovf   <= 1'b0;
            end
            if (w_accept_res) begin
                r_word <= res_data;
                r_ovf  <= r_ovf | (|res_data[31:18]);
            end
            if (w_accept_hi) begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    assign res_ready = (r_state == c_WAIT_RES);
    assign word_out  = r_word;
    assign sel_upper = (r_state == c_SEND_HI);
    assign out_valid = (r_state == c_SEND_LO) || (r_state == c_SEND_HI);
    assign out_last  = (r_state == c_SEND_HI) && w_is_last;
    assign busy      = (r_state != c_IDLE);
    assign done      = (r_state == c_DONE);
    assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_output_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_output_sequencer
// Description : Self-checking bench for output_sequencer: table frames,
//               random frames against a frame-level model, reset/idle corners.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_output_sequencer;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        res_valid;
    logic [31:0] res_data;
    logic        res_ready;
    logic [31:0] word_out;
    logic        sel_upper;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;
    logic        done;
    logic        ovf;

    int errors   = 0;
    int checks   = 0;
    int done_cnt = 0;

    typedef struct {
        logic [31:0] res;
        logic [8:0]  exp_lo;
        logic [8:0]  exp_hi;
        logic        exp_ovf;
    } vec_t;

    vec_t        tbl[12];
    logic [31:0] f_res[N];
    logic [8:0]  f_lo[N];
    logic [8:0]  f_hi[N];
    logic        f_ovf;

    output_sequencer #(.NUM_RESULTS(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_ready (res_ready),
        .word_out  (word_out),
        .sel_upper (sel_upper),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (done === 1'b1) done_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // What the downstream serialiser would present on out_data.
    function automatic logic [8:0] half_now();
        return sel_upper ? word_out[17:9] : word_out[8:0];
    endfunction

    function automatic int pick_stall(input int stall);
        return (stall < 0) ? int'($urandom_range(0, 4)) : stall;
    endfunction

    task automatic load_table_frame(input int base);
        f_ovf = 1'b0;
        for (int i = 0; i < N; i++) begin
            f_res[i] = tbl[base + i].res;
            f_lo[i]  = tbl[base + i].exp_lo;
            f_hi[i]  = tbl[base + i].exp_hi;
            f_ovf    = f_ovf | tbl[base + i].exp_ovf;
        end
    endtask

    // Frame-level reference: each result splits into 9-bit digits base 512.
    task automatic load_random_frame();
        f_ovf = 1'b0;
        for (int i = 0; i < N; i++) begin
            f_res[i] = $urandom;
            if ($urandom_range(0, 1) == 0) f_res[i] = f_res[i] % 32'h40000;
            f_lo[i] = 9'(f_res[i] % 512);
            f_hi[i] = 9'((f_res[i] / 512) % 512);
            f_ovf   = f_ovf | (f_res[i] >= 32'h40000);
        end
    endtask

    task automatic send_half(input int idx, input logic upper, input int stall, input bit poke);
        logic [8:0] exp_h;
        int         s;
        exp_h     = upper ? f_hi[idx] : f_lo[idx];
        s         = pick_stall(stall);
        out_ready = 1'b0;
        for (int k = 0; k < s; k++) begin
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_sel", 32'(sel_upper), 32'(upper));
            check("stall_half", 32'(half_now()), 32'(exp_h));
            start = poke && (k % 2 == 0);
            @(negedge clk);
        end
        start     = 1'b0;
        out_ready = 1'b1;
        check("half_valid", 32'(out_valid), 32'd1);
        check("half_sel", 32'(sel_upper), 32'(upper));
        check("half_data", 32'(half_now()), 32'(exp_h));
        check("half_last", 32'(out_last), 32'(upper && (idx == N - 1)));
        check("half_res_ready", 32'(res_ready), 32'd0);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic run_frame(input int stall, input bit poke);
        int d0;
        int w;
        d0    = done_cnt;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_start", 32'(busy), 32'd1);
        check("ovf_clear", 32'(ovf), 32'd0);
        for (int i = 0; i < N; i++) begin
            w = pick_stall(stall);
            for (int k = 0; k < w; k++) begin
                check("wait_ready", 32'(res_ready), 32'd1);
                check("wait_no_valid", 32'(out_valid), 32'd0);
                @(negedge clk);
            end
            check("res_ready", 32'(res_ready), 32'd1);
            res_valid = 1'b1;
            res_data  = f_res[i];
            start     = poke;
            @(negedge clk);
            res_valid = 1'b0;
            res_data  = $urandom;
            start     = 1'b0;
            check("word_held", word_out, f_res[i]);
            send_half(i, 1'b0, stall, poke);
            send_half(i, 1'b1, stall, poke);
        end
        check("done_pulse", 32'(done), 32'd1);
        check("done_busy", 32'(busy), 32'd1);
        check("ovf_frame", 32'(ovf), 32'(f_ovf));
        @(negedge clk);
        check("done_once", 32'(done), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("ovf_hold", 32'(ovf), 32'(f_ovf));
        @(negedge clk);
        check("done_count", 32'(done_cnt - d0), 32'd1);
        check("no_restart", 32'(busy), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_res_ready"}, 32'(res_ready), 32'd0);
        check({tag, "_word_out"}, word_out, 32'd0);
        check({tag, "_sel_upper"}, 32'(sel_upper), 32'd0);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_last"}, 32'(out_last), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_ovf"}, 32'(ovf), 32'd0);
    endtask

    initial begin
        tbl[0]  = '{32'h0000_0001, 9'h001, 9'h000, 1'b0};
        tbl[1]  = '{32'h0000_0002, 9'h002, 9'h000, 1'b0};
        tbl[2]  = '{32'h0000_0003, 9'h003, 9'h000, 1'b0};
        tbl[3]  = '{32'h0000_0004, 9'h004, 9'h000, 1'b0};
        tbl[4]  = '{32'h0003_FFFF, 9'h1FF, 9'h1FF, 1'b0};
        tbl[5]  = '{32'h0004_0000, 9'h000, 9'h000, 1'b1};
        tbl[6]  = '{32'h0001_FE00, 9'h000, 9'h0FF, 1'b0};
        tbl[7]  = '{32'h0002_0155, 9'h155, 9'h100, 1'b0};
        tbl[8]  = '{32'hFFFF_FFFF, 9'h1FF, 9'h1FF, 1'b1};
        tbl[9]  = '{32'h0000_01FF, 9'h1FF, 9'h000, 1'b0};
        tbl[10] = '{32'h0000_0200, 9'h000, 9'h001, 1'b0};
        tbl[11] = '{32'h0001_0000, 9'h000, 9'h080, 1'b0};

        rst       = 1'b1;
        start     = 1'b0;
        res_valid = 1'b0;
        res_data  = 32'd0;
        out_ready = 1'b0;
        @(negedge clk);
        check_all_zero("reset");

        // res_valid in IDLE without start must not be accepted
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            res_valid = 1'b1;
            res_data  = 32'hDEAD_BEEF;
            @(negedge clk);
            check("idle_res_ready", 32'(res_ready), 32'd0);
            check("idle_busy", 32'(busy), 32'd0);
        end
        res_valid = 1'b0;
        check("idle_word", word_out, 32'd0);

        // Table frames: no stall, fixed 5-cycle stalls, random stalls with start pokes
        load_table_frame(0);
        run_frame(0, 1'b0);
        load_table_frame(4);
        run_frame(5, 1'b0);
        load_table_frame(8);
        run_frame(-1, 1'b1);

        // Reset during SEND_HI of the second result
        start = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        res_valid = 1'b1;
        res_data  = 32'h8000_0123;
        @(negedge clk);
        res_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        res_valid = 1'b1;
        res_data  = 32'h0000_0456;
        @(negedge clk);
        res_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("pre_rst_sel", 32'(sel_upper), 32'd1);
        check("pre_rst_ovf", 32'(ovf), 32'd1);
        check("pre_rst_word", word_out, 32'h0000_0456);
        begin
            int d0;
            d0 = done_cnt;
            #2 rst = 1'b1;
            #1 check_all_zero("midrst");
            @(negedge clk);
            rst = 1'b0;
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                check("post_rst_idle", 32'(busy), 32'd0);
            end
            check("post_rst_no_done", 32'(done_cnt - d0), 32'd0);
        end
        load_table_frame(0);
        run_frame(0, 1'b0);

        // Randomised frames against the frame-level model
        for (int r = 0; r < 8; r++) begin
            load_random_frame();
            run_frame(-1, 1'($urandom_range(0, 1)));
        end

        // word_out stays at the final accepted result while idle
        for (int k = 0; k < 3; k++) begin
            res_valid = 1'b1;
            res_data  = $urandom;
            @(negedge clk);
            check("final_idle_ready", 32'(res_ready), 32'd0);
            check("final_word", word_out, f_res[N-1]);
        end
        res_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
